// File: rtl/binary_pkg.sv
// Shared types for the binary blob locator.
//   COORD_W / coord_t : pixel coordinate width (column, row, bbox edges)
//   COUNT_W / count_t : foreground pixel count width
//   state_t           : top-level sequencing FSM states
package binary_pkg;

  localparam int COORD_W = 16;
  localparam int COUNT_W = 20;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COUNT_W-1:0] count_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } state_t;

endpackage

// File: rtl/bbox_accum.sv
// Running bounding box and foreground count for one frame.
// Ports:
//   iCLK, iRST          : clock, async active-low reset (clears everything to 0)
//   clear               : start of frame; min to all-ones, max and count to 0
//   update              : fold (col,row) into the box and bump the count
//   col, row            : coordinate of the current foreground pixel
//   xMin/xMax/yMin/yMax : running box edges
//   count               : running foreground count, saturating
module bbox_accum
  import binary_pkg::*;
(
  input  logic   iCLK,
  input  logic   iRST,
  input  logic   clear,
  input  logic   update,
  input  coord_t col,
  input  coord_t row,
  output coord_t xMin,
  output coord_t xMax,
  output coord_t yMin,
  output coord_t yMax,
  output count_t count
);

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      xMin  <= '0;
      xMax  <= '0;
      yMin  <= '0;
      yMax  <= '0;
      count <= '0;
    end else if (clear) begin
      xMin  <= '1;
      xMax  <= '0;
      yMin  <= '1;
      yMax  <= '0;
      count <= '0;
    end else if (update) begin
      if (col < xMin) xMin <= col;
      if (col > xMax) xMax <= col;
      if (row < yMin) yMin <= row;
      if (row > yMax) yMax <= row;
      if (count != '1) count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/binary_blob_locator.sv
// Locates the bounding box of foreground pixels in a binary frame stream and
// reports box, count, detection flag and overrun once per frame.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for a rising edge of iFrame_En
// SCAN   | accepting valid pixels, tracking column/row and the box
// REPORT | results were just registered; oResult_Valid is high this cycle
//
// Ports:
//   iCLK, iRST      : clock, async active-low reset
//   iBinary, iDVAL  : pixel value and its valid strobe
//   iFrame_En       : high across the active frame
//   oX_Min..oY_Max  : bounding box (0 when no detection)
//   oCount          : foreground count of the last frame (saturating)
//   oFound          : oCount >= MIN_COUNT
//   oResult_Valid   : one-cycle pulse when results update
//   oOverrun        : last frame delivered more than IMG_W*IMG_H pixels
module binary_blob_locator
  import binary_pkg::*;
#(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int MIN_COUNT = 64
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iBinary,
  input  logic        iDVAL,
  input  logic        iFrame_En,
  output logic [15:0] oX_Min,
  output logic [15:0] oX_Max,
  output logic [15:0] oY_Min,
  output logic [15:0] oY_Max,
  output logic [19:0] oCount,
  output logic        oFound,
  output logic        oResult_Valid,
  output logic        oOverrun
);

  localparam coord_t LAST_COL = coord_t'(IMG_W - 1);
  // Row reaches IMG_H exactly when IMG_W*IMG_H pixels have been accepted.
  localparam coord_t FULL_ROW = coord_t'(IMG_H);
  localparam count_t MIN_CNT  = count_t'(MIN_COUNT);

  state_t state;
  logic   frameEnPrev;
  // Set once iFrame_En has been seen low, so a frame already in progress at
  // reset release is skipped rather than scanned from the middle.
  logic   frameArmed;
  coord_t col;
  coord_t row;
  logic   overrun;

  coord_t accXMin, accXMax, accYMin, accYMax;
  count_t accCount;

  logic frameRise;
  logic frameFull;
  logic pixelTake;
  logic accClear;
  logic accUpdate;
  logic accFound;

  always_comb begin
    frameRise = frameArmed & iFrame_En & ~frameEnPrev;
    frameFull = (row == FULL_ROW);
    pixelTake = (state == SCAN) & iFrame_En & iDVAL & ~frameFull;
    accUpdate = pixelTake & iBinary;
    accClear  = ((state == IDLE) & frameRise) | ((state == REPORT) & iFrame_En);
    accFound  = (accCount >= MIN_CNT);
  end

  bbox_accum uAccum (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .clear  (accClear),
    .update (accUpdate),
    .col    (col),
    .row    (row),
    .xMin   (accXMin),
    .xMax   (accXMax),
    .yMin   (accYMin),
    .yMax   (accYMax),
    .count  (accCount)
  );

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state         <= IDLE;
      frameEnPrev   <= 1'b0;
      frameArmed    <= 1'b0;
      col           <= '0;
      row           <= '0;
      overrun       <= 1'b0;
      oX_Min        <= '0;
      oX_Max        <= '0;
      oY_Min        <= '0;
      oY_Max        <= '0;
      oCount        <= '0;
      oFound        <= 1'b0;
      oResult_Valid <= 1'b0;
      oOverrun      <= 1'b0;
    end else begin
      frameEnPrev   <= iFrame_En;
      oResult_Valid <= 1'b0;
      if (!iFrame_En) frameArmed <= 1'b1;

      case (state)
        IDLE: begin
          if (frameRise) begin
            state   <= SCAN;
            col     <= '0;
            row     <= '0;
            overrun <= 1'b0;
          end
        end

        SCAN: begin
          if (!iFrame_En) begin
            // Results become visible in the REPORT cycle itself.
            state         <= REPORT;
            oResult_Valid <= 1'b1;
            oCount        <= accCount;
            oFound        <= accFound;
            oOverrun      <= overrun;
            oX_Min        <= accFound ? accXMin : '0;
            oX_Max        <= accFound ? accXMax : '0;
            oY_Min        <= accFound ? accYMin : '0;
            oY_Max        <= accFound ? accYMax : '0;
          end else if (iDVAL) begin
            if (frameFull) begin
              overrun <= 1'b1;
            end else if (col == LAST_COL) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end

        REPORT: begin
          if (iFrame_En) begin
            state   <= SCAN;
            col     <= '0;
            row     <= '0;
            overrun <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/binary_blob_locator.md
BINARY_BLOB_LOCATOR -- requirements
Module: binary_blob_locator

Interface
REQ-001 SHALL have parameter IMG_W, default 640, meaning binary pixels per line.
REQ-002 SHALL have parameter IMG_H, default 480, meaning lines per frame.
REQ-003 SHALL have parameter MIN_COUNT, default 64, meaning minimum set-pixel count for a valid detection.
REQ-004 SHALL have port iCLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port iRST, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port iBinary, input, 1 bit: pixel value, 1 = foreground (skin), 0 = background.
REQ-007 SHALL have port iDVAL, input, 1 bit: iBinary is valid this cycle.
REQ-008 SHALL have port iFrame_En, input, 1 bit: high for the whole active frame.
REQ-009 SHALL have port oX_Min, output, 16 bits: leftmost foreground column.
REQ-010 SHALL have port oX_Max, output, 16 bits: rightmost foreground column.
REQ-011 SHALL have port oY_Min, output, 16 bits: topmost foreground row.
REQ-012 SHALL have port oY_Max, output, 16 bits: bottom foreground row.
REQ-013 SHALL have port oCount, output, 20 bits: foreground pixel count of the last frame.
REQ-014 SHALL have port oFound, output, 1 bit: oCount >= MIN_COUNT.
REQ-015 SHALL have port oResult_Valid, output, 1 bit: one-cycle pulse when the results update.
REQ-016 SHALL have port oOverrun, output, 1 bit: the last frame delivered more than IMG_W*IMG_H valid pixels.

Function
REQ-017 SHALL implement the FSM IDLE -> SCAN -> REPORT -> IDLE.
REQ-018 SHALL go IDLE->SCAN on a rising edge of iFrame_En (registered previous value 0, current 1); on that transition, column, row and count clear to 0, running min set to all-ones and running max to 0.
REQ-019 SHALL, in SCAN with iDVAL=1 and iFrame_En=1, advance the column; at column IMG_W-1 it wraps to 0 and the row increments.
REQ-020 SHALL, when iBinary=1 under REQ-019, update min/max with the current column/row (before advance) and increment the count.
REQ-021 SHALL saturate count at 2^20-1.
REQ-022 SHALL, once IMG_W*IMG_H pixels have been accepted, ignore further pixels and set the internal overrun flag.
REQ-023 SHALL ignore iDVAL in IDLE and REPORT, and whenever iFrame_En=0.
REQ-024 SHALL go SCAN->REPORT on iFrame_En=0; a short frame reports whatever was accumulated.
REQ-025 SHALL, in REPORT, register all result outputs and assert oResult_Valid for exactly that cycle.
REQ-026 SHALL hold result outputs stable between pulses.
REQ-027 SHALL drive oX_Min, oX_Max, oY_Min and oY_Max as 0 when oFound=0; oCount is always the true saturated count.
REQ-028 SHALL go REPORT->SCAN (fresh clear per REQ-018) if iFrame_En=1 in the REPORT cycle, else REPORT->IDLE.
REQ-029 SHALL make results visible exactly 1 cycle after iFrame_En is first sampled low in SCAN.

Reset
REQ-030 SHALL, on iRST=0 at any time including mid-frame, immediately force state IDLE, all outputs 0, all counters and accumulators cleared, and edge-detect register 0.
REQ-031 SHALL, after reset release with iFrame_En already high, wait for the next rising edge before scanning.

Structure
REQ-032 SHALL define the state enum, the 16-bit coordinate width and the 20-bit count width in shared package binary_pkg.
REQ-033 SHALL instantiate one sub-module bbox_accum that holds the running min/max/count with clear and update strobes; FSM and column/row counters stay in the top level.

Verification
REQ-034 SHALL cover: IMG_W=8, IMG_H=4, MIN_COUNT=2, foreground at (2,1),(5,1),(3,3) -> pulse with X 2..5, Y 1..3, count 3, oFound=1.
REQ-035 SHALL cover: same parameters, single foreground pixel -> count 1, oFound=0, all bbox outputs 0.
REQ-036 SHALL cover: 40 valid pixels in one frame (>32) -> oOverrun=1, count covers only the first 32.
REQ-037 SHALL cover: iRST low mid-SCAN -> outputs 0, no oResult_Valid; next frame reports normally.
REQ-038 SHALL cover: iFrame_En low for exactly one cycle between frames -> two pulses, second frame independent of the first.
REQ-039 SHALL cover: iDVAL gaps inside a line and pixels while iFrame_En=0 -> coordinates unaffected, ignored pixels not counted.
